// File: rtl/ctrl_seq_bh.sv
// SAP-1 controller-sequencer: a six-state ring (T1..T6) that decodes the register control word.
// Latency: the strobes are combinational from the T register, the HALT register and OPCODE. T advances once per CLK.
// Backpressure: none. The ring free-runs until HLT freezes it, and only CLR releases the freeze.
//
// Ports:
//   CLK     system clock, rising edge
//   CLR     synchronous active-high reset; forces all strobes low while high
//   OPCODE  IR upper nibble, held stable from T4 through T6
//   T       one-hot ring state, T[0]=T1 .. T[5]=T6
//   CP/EP   PC increment / PC onto bus
//   LM      MAR load
//   CE      RAM onto bus
//   LI/EI   IR load / IR address nibble onto bus
//   LA/EA   A load / A onto bus
//   SU/EU   ALU subtract select / ALU onto bus
//   LB      B load
//   LO      OUT load
//   HALT    sticky halt flag
module ctrl_seq_bh #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [3:0] OPCODE,
  output logic [5:0] T,
  output logic       CP,
  output logic       EP,
  output logic       LM,
  output logic       CE,
  output logic       LI,
  output logic       EI,
  output logic       LA,
  output logic       EA,
  output logic       SU,
  output logic       EU,
  output logic       LB,
  output logic       LO,
  output logic       HALT
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } ring_t;

  ring_t ring_q, ring_d;
  logic  halt_q, halt_d;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      ring_q <= T1;
      halt_q <= 1'b0;
    end else begin
      ring_q <= ring_d;
      halt_q <= halt_d;
    end
  end

  always_comb begin
    ring_d = ring_q;
    halt_d = halt_q;
    CP = 1'b0; EP = 1'b0; LM = 1'b0; CE = 1'b0;
    LI = 1'b0; EI = 1'b0; LA = 1'b0; EA = 1'b0;
    SU = 1'b0; EU = 1'b0; LB = 1'b0; LO = 1'b0;

    // Ring advance. A halted ring holds its state and ignores OPCODE.
    if (!halt_q) begin
      case (ring_q)
        T1: ring_d = T2;
        T2: ring_d = T3;
        T3: ring_d = T4;
        // HLT parks the ring on T4. HALT then keeps it there.
        T4: if (OPCODE == OP_HLT) halt_d = 1'b1;
            else                  ring_d = T5;
        T5: ring_d = T6;
        T6: ring_d = T1;
        default: ring_d = T1;
      endcase
    end

    // Control word decode. CLR masks the strobes so that an aborted
    // instruction cannot disturb any register during the reset cycle.
    if (!CLR && !halt_q) begin
      case (ring_q)
        T1: begin EP = 1'b1; LM = 1'b1; end
        T2: CP = 1'b1;
        T3: begin CE = 1'b1; LI = 1'b1; end
        T4: begin
          if (OPCODE == OP_LDA || OPCODE == OP_ADD || OPCODE == OP_SUB) begin
            EI = 1'b1; LM = 1'b1;
          end else if (OPCODE == OP_OUT) begin
            EA = 1'b1; LO = 1'b1;
          end
        end
        T5: begin
          if (OPCODE == OP_LDA) begin
            CE = 1'b1; LA = 1'b1;
          end else if (OPCODE == OP_ADD || OPCODE == OP_SUB) begin
            CE = 1'b1; LB = 1'b1;
          end
        end
        T6: begin
          if (OPCODE == OP_ADD || OPCODE == OP_SUB) begin
            LA = 1'b1; EU = 1'b1;
            SU = (OPCODE == OP_SUB);
          end
        end
        default: ;
      endcase
    end

    T    = ring_q;
    HALT = halt_q;
  end

endmodule

// File: tb/tb_ctrl_seq_bh.sv
// Directed bench for ctrl_seq_bh: it steps the ring and compares T, HALT and the strobe word against hand-computed values.
// Latency: the bench samples 1 time unit after each rising CLK and changes inputs only at those points.
// Backpressure: not applicable.
module tb_ctrl_seq_bh;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic [3:0] OPCODE = 4'h0;
  logic [5:0] T;
  logic CP, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO, HALT;

  ctrl_seq_bh dut (
    .CLK(CLK), .CLR(CLR), .OPCODE(OPCODE), .T(T),
    .CP(CP), .EP(EP), .LM(LM), .CE(CE), .LI(LI), .EI(EI),
    .LA(LA), .EA(EA), .SU(SU), .EU(EU), .LB(LB), .LO(LO),
    .HALT(HALT)
  );

  always #5 CLK = ~CLK;

  // Strobe word order: {CP,EP,LM,CE,LI,EI,LA,EA,SU,EU,LB,LO}
  localparam logic [11:0] S_CP = 12'h800, S_EP = 12'h400, S_LM = 12'h200,
                          S_CE = 12'h100, S_LI = 12'h080, S_EI = 12'h040,
                          S_LA = 12'h020, S_EA = 12'h010, S_SU = 12'h008,
                          S_EU = 12'h004, S_LB = 12'h002, S_LO = 12'h001,
                          S_NONE = 12'h000;

  localparam logic [5:0] T1 = 6'b000001, T2 = 6'b000010, T3 = 6'b000100,
                         T4 = 6'b001000, T5 = 6'b010000, T6 = 6'b100000;

  int n_checks = 0;
  int n_pass   = 0;

  logic [11:0] strobes;
  logic [4:0]  bus_drv;
  assign strobes = {CP, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO};
  assign bus_drv = {EP, CE, EI, EA, EU};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Checks the current cycle: T, HALT, the strobe word and the structural invariants.
  task automatic cyc(input string tag, input logic [5:0] exp_t, input logic exp_halt,
                     input logic [11:0] exp_s);
    chk({tag, ".T"}, {10'd0, T}, {10'd0, exp_t});
    chk({tag, ".HALT"}, {15'd0, HALT}, {15'd0, exp_halt});
    chk({tag, ".strobes"}, {4'd0, strobes}, {4'd0, exp_s});
    chk({tag, ".onehot"}, {15'd0, $onehot(T)}, 16'd1);
    chk({tag, ".bus"}, {15'd0, ($countones(bus_drv) <= 1)}, 16'd1);
    chk({tag, ".su_eu"}, {15'd0, (!SU || EU)}, 16'd1);
  endtask

  // Runs one full instruction that starts at T1 and confirms the wrap back to T1.
  task automatic run_instr(input string tag, input logic [3:0] op,
                           input logic [11:0] e4, input logic [11:0] e5, input logic [11:0] e6);
    OPCODE = op;
    #1;
    cyc({tag, ".t1"}, T1, 1'b0, S_EP | S_LM); tick();
    cyc({tag, ".t2"}, T2, 1'b0, S_CP);        tick();
    cyc({tag, ".t3"}, T3, 1'b0, S_CE | S_LI); tick();
    cyc({tag, ".t4"}, T4, 1'b0, e4);          tick();
    cyc({tag, ".t5"}, T5, 1'b0, e5);          tick();
    cyc({tag, ".t6"}, T6, 1'b0, e6);          tick();
    chk({tag, ".wrap"}, {10'd0, T}, {10'd0, T1});
  endtask

  initial begin
    // Hold CLR for two clocks. The strobes stay masked while CLR is high.
    CLR = 1'b1;
    tick();
    chk("rst.strobes_masked", {4'd0, strobes}, 16'd0);
    tick();
    chk("rst.T", {10'd0, T}, {10'd0, T1});
    chk("rst.HALT", {15'd0, HALT}, 16'd0);
    CLR = 1'b0;
    #1;

    run_instr("lda", 4'h0, S_EI | S_LM, S_CE | S_LA, S_NONE);
    run_instr("sub", 4'h2, S_EI | S_LM, S_CE | S_LB, S_LA | S_EU | S_SU);
    run_instr("add", 4'h1, S_EI | S_LM, S_CE | S_LB, S_LA | S_EU);
    run_instr("out", 4'hE, S_EA | S_LO, S_NONE, S_NONE);
    run_instr("nop", 4'h7, S_NONE, S_NONE, S_NONE);

    // HLT freezes the ring on T4. OPCODE wiggles while halted and must be ignored.
    OPCODE = 4'hF;
    #1;
    cyc("hlt.t1", T1, 1'b0, S_EP | S_LM); tick();
    cyc("hlt.t2", T2, 1'b0, S_CP);        tick();
    cyc("hlt.t3", T3, 1'b0, S_CE | S_LI); tick();
    cyc("hlt.t4", T4, 1'b0, S_NONE);      tick();
    for (int i = 0; i < 20; i++) begin
      cyc("hlt.frozen", T4, 1'b1, S_NONE);
      OPCODE = 4'(i);
      tick();
    end
    CLR = 1'b1;
    #1;
    chk("hlt.clr_masked", {4'd0, strobes}, 16'd0);
    tick();
    CLR = 1'b0;
    #1;
    cyc("hlt.after_clr", T1, 1'b0, S_EP | S_LM);

    // CLR during T5 of ADD aborts the instruction. The next cycle is T1.
    OPCODE = 4'h1;
    #1;
    cyc("abort.t1", T1, 1'b0, S_EP | S_LM); tick();
    cyc("abort.t2", T2, 1'b0, S_CP);        tick();
    cyc("abort.t3", T3, 1'b0, S_CE | S_LI); tick();
    cyc("abort.t4", T4, 1'b0, S_EI | S_LM); tick();
    cyc("abort.t5", T5, 1'b0, S_CE | S_LB);
    CLR = 1'b1;
    #1;
    cyc("abort.t5_clr", T5, 1'b0, S_NONE);
    tick();
    CLR = 1'b0;
    #1;
    run_instr("post_abort", 4'h1, S_EI | S_LM, S_CE | S_LB, S_LA | S_EU);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
